// File: rtl/cci_mpf_prim_repl_lru_pkg.sv
// ============================================================================
// cci_mpf_prim_repl_lru_pkg
//
// Shared constants and types for the pseudo-LRU replacement table client
// controller (cci_mpf_prim_repl_lru_ctrl) and its hit FIFO.
//
//   LRU_LOOKUP_LATENCY : cycles from lookupEn to lookupRspRdy in the table.
//   LRU_HAZARD_CYCLES  : cycles a just-filled set stays blocked for new misses,
//                        covering the table's read-modify-write window.
//   t_lru_ctrl_state   : miss state machine encoding.
// ============================================================================
package cci_mpf_prim_repl_lru_pkg;

    localparam int LRU_LOOKUP_LATENCY = 3;
    localparam int LRU_HAZARD_CYCLES  = 4;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_LOOKUP = 2'd1,
        STATE_WAIT   = 2'd2,
        STATE_RSP    = 2'd3
    } t_lru_ctrl_state;

endpackage

// File: rtl/cci_mpf_prim_repl_lru_hit_fifo.sv
// ============================================================================
// cci_mpf_prim_repl_lru_hit_fifo
//
// Buffers best-effort hit reports and drains one per cycle onto LRU table
// port 1. Hits with an all-zero way vector are ignored. A hit arriving while
// the FIFO is full (registered count) is dropped and counted in a saturating
// 16-bit counter; a same-cycle dequeue does not make room.
//
// Optional feature, macro CCI_MPF_LRU_CTRL_HIT_COALESCE_EN: a hit whose index
// matches the tail entry is OR-merged into it, unless that tail is also the
// head leaving in the same cycle. A merged hit is never a drop.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   hit_en_i        hit report strobe
//   hit_idx_i       set index of the hit
//   hit_vec_i       referenced ways
//   drain_ok_i      table may accept a port-1 reference this cycle
//   ref_en_o        registered port-1 reference strobe
//   ref_idx_o       registered port-1 set index
//   ref_vec_o       registered port-1 way vector
//   drop_cnt_o      saturating count of dropped hits
// ============================================================================
module cci_mpf_prim_repl_lru_hit_fifo #(
    parameter int N_WAYS    = 4,
    parameter int N_ENTRIES = 1024,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hit_en_i,
    input  logic [$clog2(N_ENTRIES)-1:0] hit_idx_i,
    input  logic [N_WAYS-1:0]            hit_vec_i,
    input  logic                         drain_ok_i,
    output logic                         ref_en_o,
    output logic [$clog2(N_ENTRIES)-1:0] ref_idx_o,
    output logic [N_WAYS-1:0]            ref_vec_o,
    output logic [15:0]                  drop_cnt_o
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [IDX_W-1:0]  t_idx;
    typedef logic [N_WAYS-1:0] t_vec;
    typedef struct packed {
        t_idx idx;
        t_vec vec;
    } t_hit;

    t_hit              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       drop_q;
    logic              ref_en_q;
    t_idx              ref_idx_q;
    t_vec              ref_vec_q;

    logic empty, full, hit_vld, deq, merge, enq, drop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign hit_vld = hit_en_i && (hit_vec_i != '0);
    assign deq     = !empty && drain_ok_i;

`ifdef CCI_MPF_LRU_CTRL_HIT_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr;
    assign tail_ptr = wr_ptr_q - 1'b1;
    // A single-entry FIFO that drains this cycle has no stable tail to merge into.
    assign merge = hit_vld && !empty && (mem_q[tail_ptr].idx == hit_idx_i) &&
                   !(deq && (cnt_q == CNT_W'(1)));
`else
    assign merge = 1'b0;
`endif

    assign enq  = hit_vld && !merge && !full;
    assign drop = hit_vld && !merge && full;

    // NOTE: storage array is deliberately not reset; the pointers and count
    // define which entries are valid, so clearing the data buys nothing.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= {hit_idx_i, hit_vec_i};
`ifdef CCI_MPF_LRU_CTRL_HIT_COALESCE_EN
        if (merge) mem_q[tail_ptr].vec <= mem_q[tail_ptr].vec | hit_vec_i;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            ref_en_q  <= 1'b0;
            ref_idx_q <= '0;
            ref_vec_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            ref_en_q <= deq;
            if (deq) begin
                ref_idx_q <= mem_q[rd_ptr_q].idx;
                ref_vec_q <= mem_q[rd_ptr_q].vec;
            end
        end
    end

    assign ref_en_o   = ref_en_q;
    assign ref_idx_o  = ref_idx_q;
    assign ref_vec_o  = ref_vec_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/cci_mpf_prim_repl_lru_ctrl.sv
// ============================================================================
// cci_mpf_prim_repl_lru_ctrl
//
// Client-side controller for the pseudo-LRU table. Victim requests from the
// miss path run IDLE -> LOOKUP -> WAIT -> RSP; the accepted victim is written
// back as a fill reference on table port 0 and the set is blocked for new
// misses for LRU_HAZARD_CYCLES. Hit reports are buffered in a small FIFO and
// drained onto table port 1 when the table is ready and no lookup is issued.
//
// Optional feature macro: CCI_MPF_LRU_CTRL_HIT_COALESCE_EN (tail merging of
// hits to the same set inside the hit FIFO).
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   missValid/missReady/missIdx         victim request
//   victimValid/victimReady             victim response handshake
//   victimWay/victimVec                 victim as index and one-hot vector
//   hitEn/hitIdx/hitWayVec              best-effort hit report
//   hitDropCnt                          saturating dropped-hit count
//   lruRdy                              table ready
//   lookupEn/lookupIdx                  table lookup request
//   lookupRspRdy/lookupRsp/lookupVecRsp table lookup response
//   refEn0/refIdx0/refWayVec0           table port 0 (fills)
//   refEn1/refIdx1/refWayVec1           table port 1 (hits)
// ============================================================================
module cci_mpf_prim_repl_lru_ctrl
    import cci_mpf_prim_repl_lru_pkg::*;
#(
    parameter int N_WAYS        = 4,
    parameter int N_ENTRIES     = 1024,
    parameter int HIT_BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         missValid,
    output logic                         missReady,
    input  logic [$clog2(N_ENTRIES)-1:0] missIdx,
    output logic                         victimValid,
    input  logic                         victimReady,
    output logic [$clog2(N_WAYS)-1:0]    victimWay,
    output logic [N_WAYS-1:0]            victimVec,
    input  logic                         hitEn,
    input  logic [$clog2(N_ENTRIES)-1:0] hitIdx,
    input  logic [N_WAYS-1:0]            hitWayVec,
    output logic [15:0]                  hitDropCnt,
    input  logic                         lruRdy,
    output logic                         lookupEn,
    output logic [$clog2(N_ENTRIES)-1:0] lookupIdx,
    input  logic                         lookupRspRdy,
    input  logic [$clog2(N_WAYS)-1:0]    lookupRsp,
    input  logic [N_WAYS-1:0]            lookupVecRsp,
    output logic                         refEn0,
    output logic [$clog2(N_ENTRIES)-1:0] refIdx0,
    output logic [N_WAYS-1:0]            refWayVec0,
    output logic                         refEn1,
    output logic [$clog2(N_ENTRIES)-1:0] refIdx1,
    output logic [N_WAYS-1:0]            refWayVec1
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int WAY_W = $clog2(N_WAYS);
    localparam int HAZ_W = $clog2(LRU_HAZARD_CYCLES + 1);

    typedef logic [IDX_W-1:0]  t_idx;
    typedef logic [WAY_W-1:0]  t_way;
    typedef logic [N_WAYS-1:0] t_vec;

    t_lru_ctrl_state  state_q, state_d;
    t_idx             idx_q;
    t_way             way_q;
    t_vec             vec_q;
    logic [HAZ_W-1:0] haz_cnt_q;
    t_idx             haz_idx_q;
    logic             ref_en0_q;
    t_idx             ref_idx0_q;
    t_vec             ref_vec0_q;

    logic hazard, miss_hs, victim_hs;

    // Same-set miss is held off while the table is still updating that set.
    assign hazard    = (haz_cnt_q != '0) && (missIdx == haz_idx_q);
    assign miss_hs   = missValid && missReady;
    assign victim_hs = victimValid && victimReady;

    always_ff @(posedge clk) begin
        if (reset) state_q <= STATE_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        missReady   = 1'b0;
        lookupEn    = 1'b0;
        victimValid = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                missReady = lruRdy && !hazard && !reset;
                if (missValid && missReady) state_d = STATE_LOOKUP;
            end
            STATE_LOOKUP: begin
                lookupEn = 1'b1;
                state_d  = STATE_WAIT;
            end
            STATE_WAIT: begin
                if (lookupRspRdy) state_d = STATE_RSP;
            end
            STATE_RSP: begin
                victimValid = 1'b1;
                if (victimReady) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            way_q      <= '0;
            vec_q      <= '0;
            haz_cnt_q  <= '0;
            haz_idx_q  <= '0;
            ref_en0_q  <= 1'b0;
            ref_idx0_q <= '0;
            ref_vec0_q <= '0;
        end else begin
            if (miss_hs) idx_q <= missIdx;
            // Response is only meaningful in WAIT; stray strobes elsewhere are dropped.
            if ((state_q == STATE_WAIT) && lookupRspRdy) begin
                way_q <= lookupRsp;
                vec_q <= lookupVecRsp;
            end
            ref_en0_q <= victim_hs;
            if (victim_hs) begin
                ref_idx0_q <= idx_q;
                ref_vec0_q <= vec_q;
                haz_cnt_q  <= HAZ_W'(LRU_HAZARD_CYCLES);
                haz_idx_q  <= idx_q;
            end else if (haz_cnt_q != '0) begin
                haz_cnt_q <= haz_cnt_q - 1'b1;
            end
        end
    end

    assign lookupIdx  = idx_q;
    assign victimWay  = way_q;
    assign victimVec  = vec_q;
    assign refEn0     = ref_en0_q;
    assign refIdx0    = ref_idx0_q;
    assign refWayVec0 = ref_vec0_q;

    cci_mpf_prim_repl_lru_hit_fifo #(
        .N_WAYS    (N_WAYS),
        .N_ENTRIES (N_ENTRIES),
        .DEPTH     (HIT_BUF_DEPTH)
    ) u_hit_fifo (
        .clk        (clk),
        .reset      (reset),
        .hit_en_i   (hitEn),
        .hit_idx_i  (hitIdx),
        .hit_vec_i  (hitWayVec),
        .drain_ok_i (lruRdy && !lookupEn),
        .ref_en_o   (refEn1),
        .ref_idx_o  (refIdx1),
        .ref_vec_o  (refWayVec1),
        .drop_cnt_o (hitDropCnt)
    );

endmodule

// File: doc/cci_mpf_prim_repl_lru_ctrl.md
# cci_mpf_prim_repl_lru_ctrl

Client-side controller for the pseudo-LRU replacement table (`cci_mpf_prim_repl_lru_pseudo`). It accepts victim-selection requests from a cache miss path and drives the table's lookup port. It returns the chosen victim way and records the fill as a reference on table port 0. Hit reports from the cache hit path are buffered, optionally coalesced, and drained onto table port 1.

## Interface
- N_WAYS, 4, associativity; must match the LRU table.
- N_ENTRIES, 1024, number of sets; must match the LRU table.
- HIT_BUF_DEPTH, 4, hit FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- missValid / missReady  in / out  1 / 1  victim request handshake.
- missIdx  in  clog2(N_ENTRIES)  set index of the miss.
- victimValid / victimReady  out / in  1 / 1  victim response handshake.
- victimWay  out  clog2(N_WAYS)  victim way, as an index.
- victimVec  out  N_WAYS  victim way, as a one-hot vector.
- hitEn  in  1  hit report; best effort, no back-pressure.
- hitIdx  in  clog2(N_ENTRIES)  set index of the hit.
- hitWayVec  in  N_WAYS  ways referenced by the hit.
- hitDropCnt  out  16  saturating count of dropped hits.
- lruRdy  in  1  LRU table `rdy`.
- lookupEn / lookupIdx  out  1 / clog2(N_ENTRIES)  to LRU table.
- lookupRspRdy, lookupRsp, lookupVecRsp  in  1, clog2(N_WAYS), N_WAYS  from LRU table.
- refEn0 / refIdx0 / refWayVec0  out  table port 0 (fills).
- refEn1 / refIdx1 / refWayVec1  out  table port 1 (hits).

## Operation
- The miss state machine has four states: IDLE, LOOKUP, WAIT, RSP.
- IDLE:
  - missReady = lruRdy && !hazard.
  - On a missValid && missReady handshake, capture missIdx and go to LOOKUP.
- LOOKUP:
  - lookupEn = 1 for exactly one cycle, with lookupIdx = the captured index.
  - Go to WAIT.
- WAIT:
  - On lookupRspRdy, capture lookupRsp and lookupVecRsp, then go to RSP.
  - lookupRspRdy is ignored in every other state.
- RSP:
  - victimValid = 1. victimWay and victimVec are held stable until victimReady.
  - On the victimValid && victimReady handshake:
    - next cycle: refEn0 = 1 for one cycle, with refIdx0 = the captured index and refWayVec0 = victimVec;
    - load the hazard counter with 4 and record the captured index;
    - go to IDLE.
- Hazard: active while the hazard counter is non-zero and missIdx equals the recorded index. The counter decrements once per cycle down to 0. This covers the table's internal read-modify-write window, so a second miss to the same set cannot receive the same victim.
- Hit FIFO (HIT_BUF_DEPTH entries of {idx, vec}):
  - Enqueue when hitEn = 1 and hitWayVec != 0. A zero vector is ignored.
  - When the FIFO is full (judged on the registered count), the hit is dropped and hitDropCnt increments, saturating at 0xFFFF. A same-cycle dequeue does not make room.
  - Dequeue one entry per cycle when the FIFO is non-empty, lruRdy = 1 and lookupEn = 0. refEn1, refIdx1 and refWayVec1 are registered outputs driven from the dequeued entry.
  - While lookupEn = 1, the head entry is held and not dequeued.
- Reset values:
  - missReady, victimValid, lookupEn, refEn0 and refEn1 are 0.
  - victimWay, victimVec, lookupIdx, refIdx* and refWayVec* are 0.
  - hitDropCnt is 0; the FIFO is empty; the hazard counter is 0; the state is IDLE.
- Reset mid-operation abandons any in-flight lookup and victim response. A late lookupRspRdy arriving after reset is discarded.

## Timing
- Miss accepted in cycle T:
  - lookupEn in T+1;
  - lookupRspRdy in T+4 (the table has 3-cycle latency);
  - victimValid in T+5;
  - refEn0 in the cycle after the victim handshake.
- Minimum miss-to-miss spacing is 6 cycles. A miss to the same set is additionally delayed by the hazard window.
- Hit enqueued in cycle T: refEn1 no earlier than T+2.
- lruRdy low: no new miss is accepted and the FIFO does not drain. Hits continue to enqueue. A miss already in progress completes normally.

## Configuration
- CCI_MPF_LRU_CTRL_HIT_COALESCE_EN defined:
  - An incoming hit whose idx equals the tail entry's idx is merged into that entry: vec = tail.vec | hitWayVec.
  - Merging is skipped when the tail entry is also the head being dequeued in the same cycle.
  - A merged hit never counts as a drop, even when the FIFO is full.
- Not defined: every accepted hit occupies its own entry.

## Structure
- Package `cci_mpf_prim_repl_lru_pkg` holds:
  - LRU_LOOKUP_LATENCY = 3;
  - LRU_HAZARD_CYCLES = 4;
  - the state enum t_lru_ctrl_state.
- Index and vector types are local typedefs derived from the module parameters.
- Sub-module `cci_mpf_prim_repl_lru_hit_fifo`: the hit FIFO with optional tail coalescing, drop counter and full/empty flags.

## Test plan
- Miss idx 5, LRU returns vec 4'b0100 at T+4, victimReady held high:
  - victimWay = 2 at T+5;
  - refEn0 with refIdx0 = 5 and refWayVec0 = 4'b0100 at T+6.
- Back-to-back misses to idx 9 with victimReady high: the second missReady stays 0 until the hazard counter reaches 0; lookupEn for the second miss appears at least 4 cycles after the first refEn0.
- Five hits to distinct idx 0..4 in consecutive cycles, with lookupEn forced high to stall draining: four are accepted, hitDropCnt = 1, and refEn1 drains idx 0..3 in order.
- Coalesce macro defined: hits {idx 7, 4'b0001} then {idx 7, 4'b0010}, FIFO otherwise stalled:
  - a single refEn1 with refWayVec1 = 4'b0011;
  - macro undefined: two refEn1 pulses.
- Reset asserted while in WAIT, with lookupRspRdy arriving 1 cycle after reset deasserts: victimValid stays 0 and the state is IDLE.
- lruRdy = 0 with missValid = 1: missReady = 0, lookupEn = 0 and refEn1 = 0; all resume within 1 cycle of lruRdy rising.
